// File: rtl/fn1_mul_acc_pkg.sv
// fn1 multiplier-drain accumulator: shared constants, state type, sizing.
// Optional saturation is enabled with FN1_ACC_SAT_EN.
package fn1_mul_acc_pkg;

  function automatic int acc_w_req(
    input int prod_w,
    input int acc_len
  );
    return prod_w + $clog2(acc_len);
  endfunction

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_PROD_W  = 20;
  localparam int DEF_ACC_LEN = 16;
  localparam int DEF_ACC_W   =
    acc_w_req(DEF_PROD_W, DEF_ACC_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fn1_vld_track.sv
// ce-gated valid/last tracker mirroring the multiplier pipeline.
// Tail bits line up with the multiplier product output.
module fn1_vld_track
  import fn1_mul_acc_pkg::*;
#(
  parameter int DEPTH = DEF_MUL_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ce,
  input  logic i_vld,
  input  logic i_last,
  output logic o_vld,
  output logic o_last
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_last <= '0;
    end else if (i_ce) begin
      r_vld  <= (r_vld << 1) | DEPTH'(i_vld);
      r_last <= (r_last << 1)
              | DEPTH'(i_vld && i_last);
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_last = r_last[DEPTH-1];

endmodule

// File: rtl/fn1_mul_acc_drain.sv
// Drains the 11x9 pipelined multiplier, sums product groups, and
// presents each sum on valid/ready. FN1_ACC_SAT_EN: saturating sums.
module fn1_mul_acc_drain
  import fn1_mul_acc_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_LEN = DEF_ACC_LEN,
  parameter int ACC_W   = acc_w_req(PROD_W, ACC_LEN),
  parameter int CNT_W   = $clog2(ACC_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mul_ce,
  input  logic [PROD_W-1:0] mul_dout,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ovf
);

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ocnt;
  logic             r_flag;
  logic             r_ovf;

  logic             w_ce;
  logic             w_vld_t;
  logic             w_last_t;
  logic             w_tail;
  logic             w_close;
  logic             w_carry;
  logic [ACC_W:0]   w_nsum;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt1;

  // A held, unaccepted result freezes the whole multiplier pipeline.
  assign w_ce = !(r_state == HOLD && !out_ready);

  fn1_vld_track #(
    .DEPTH (MUL_LAT)
  ) u_track (
    .clk    (clk),
    .rst_n  (reset),
    .i_ce   (w_ce),
    .i_vld  (in_valid),
    .i_last (in_last),
    .o_vld  (w_vld_t),
    .o_last (w_last_t)
  );

  assign w_tail  = w_ce && w_vld_t;
  assign w_nsum  = {1'b0, r_acc}
                 + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_dout};
  assign w_carry = w_nsum[ACC_W];
  assign w_cnt1  = r_cnt + CNT_W'(1);
  assign w_close = w_tail
                && (w_cnt1 == CNT_W'(ACC_LEN) || w_last_t);

`ifdef FN1_ACC_SAT_EN
  // Once clamped, any further add carries again and stays clamped.
  assign w_sum = w_carry ? {ACC_W{1'b1}}
                         : w_nsum[ACC_W-1:0];
`else
  assign w_sum = w_nsum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: begin
        if (w_close) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready && !w_close) w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_data  <= '0;
      r_ocnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tail) begin
        if (w_close) begin
          r_data <= w_sum;
          r_ocnt <= w_cnt1;
          r_ovf  <= r_flag | w_carry;
          r_acc  <= '0;
          r_cnt  <= '0;
          r_flag <= 1'b0;
        end else begin
          r_acc  <= w_sum;
          r_cnt  <= w_cnt1;
          r_flag <= r_flag | w_carry;
        end
      end
    end
  end

  assign mul_ce    = w_ce;
  assign in_ready  = w_ce;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_cnt   = r_ocnt;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_fn1_mul_acc_drain.sv
// Scoreboard bench for fn1_mul_acc_drain: 24-bit and 20-bit instances
// fed by a behavioural 4-stage ce-gated multiplier each.
module tb_fn1_mul_acc_drain;

  localparam int LAT = 4;
  localparam int PW  = 20;
  localparam int LEN = 16;
  localparam int AW  = 24;
  localparam int AW2 = 20;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic [10:0] a;
  logic [8:0]  b;

  logic           rdy0, ce0, ov0, ovf0;
  logic [PW-1:0]  md0;
  logic [AW-1:0]  od0;
  logic [CW-1:0]  oc0;
  logic           rdy1, ce1, ov1, ovf1;
  logic [PW-1:0]  md1;
  logic [AW2-1:0] od1;
  logic [CW-1:0]  oc1;

  logic [PW-1:0] mp0 [LAT];
  logic [PW-1:0] mp1 [LAT];

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] cnt;
    logic        v0;
    logic        v1;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int cyc    = 0;
  int t_val  = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (ce0) begin
      mp0[0] <= PW'(a) * PW'(b);
      for (int i = 1; i < LAT; i++) mp0[i] <= mp0[i-1];
    end
    if (ce1) begin
      mp1[0] <= PW'(a) * PW'(b);
      for (int i = 1; i < LAT; i++) mp1[i] <= mp1[i-1];
    end
  end
  assign md0 = mp0[LAT-1];
  assign md1 = mp1[LAT-1];

  fn1_mul_acc_drain #(
    .MUL_LAT (LAT), .PROD_W (PW), .ACC_LEN (LEN),
    .ACC_W (AW), .CNT_W (CW)
  ) u_dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_last (in_last),
    .in_ready (rdy0), .mul_ce (ce0), .mul_dout (md0),
    .out_data (od0), .out_cnt (oc0), .out_valid (ov0),
    .out_ready (out_ready), .out_ovf (ovf0)
  );

  fn1_mul_acc_drain #(
    .MUL_LAT (LAT), .PROD_W (PW), .ACC_LEN (LEN),
    .ACC_W (AW2), .CNT_W (CW)
  ) u_dut20 (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_last (in_last),
    .in_ready (rdy1), .mul_ce (ce1), .mul_dout (md1),
    .out_data (od1), .out_cnt (oc1), .out_valid (ov1),
    .out_ready (out_ready), .out_ovf (ovf1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic void acc_step(
    input longint p, input int w,
    inout longint s, inout bit f
  );
    longint mx;
    mx = (longint'(1) << w) - 1;
    s  = s + p;
    if (s > mx) begin
      f = 1'b1;
`ifdef FN1_ACC_SAT_EN
      s = mx;
`else
      s = s - (mx + 1);
`endif
    end
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("rdy_eq_ce", rdy0, ce0);
      check("ce_rule", ce0, !(ov0 && !out_ready));
      if (ov0 && t_val < 0) t_val = cyc;
      if (ov0 && out_ready) begin
        exp_t e;
        n_out++;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("data24", od0, e.d0);
          check("cnt24", oc0, e.cnt);
          check("ovf24", ovf0, e.v0);
          check("valid20", ov1, 1);
          check("data20", od1, e.d1);
          check("cnt20", oc1, e.cnt);
          check("ovf20", ovf1, e.v1);
        end
      end
    end
  end

  task automatic send(
    input logic v, input logic l,
    input logic [10:0] aa, input logic [8:0] bb
  );
    bit ok;
    int g;
    g = 0;
    in_valid = v; in_last = l; a = aa; b = bb;
    do begin
      @(negedge clk);
      ok = rdy0 && rdy1;
      @(posedge clk); #1;
      g++;
    end while (!ok && g < 200);
    if (!ok) check("send_timeout", ok, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic group(
    input int n, input bit use_last,
    input logic [10:0] aa, input logic [8:0] bb,
    input bit rnd
  );
    longint s0, s1;
    bit f0, f1;
    logic [10:0] x;
    logic [8:0]  y;
    exp_t e;
    s0 = 0; s1 = 0; f0 = 0; f1 = 0;
    for (int i = 0; i < n; i++) begin
      x = rnd ? 11'($urandom) : aa;
      y = rnd ? 9'($urandom)  : bb;
      acc_step(longint'(x) * longint'(y), AW, s0, f0);
      acc_step(longint'(x) * longint'(y), AW2, s1, f1);
      if (i == n - 1) begin
        e.d0 = s0[31:0]; e.d1 = s1[31:0];
        e.cnt = n; e.v0 = f0; e.v1 = f1;
        sb.push_back(e);
      end
      send(1'b1, use_last && (i == n - 1), x, y);
    end
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    logic [AW-1:0] held;
    exp_t e;
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ov0, 0);
    check("rst_data", od0, 0);
    check("rst_cnt", oc0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_ce", ce0, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // full group of 16, closed by count
    n_out = 0; t_val = -1; t0 = cyc;
    group(16, 1'b0, 11'd2047, 9'd511, 1'b0);
    drain(60);
    check("latency", t_val - t0, LAT + 16);
    repeat (6) @(posedge clk);
    #1;
    check("pulse_once", n_out, 1);

    // in_last closes, next group from zero
    group(3, 1'b1, 11'd3, 9'd5, 1'b0);
    group(2, 1'b1, 11'd3, 9'd5, 1'b0);
    group(1, 1'b1, 11'd5, 9'd6, 1'b0);
    group(1, 1'b1, 11'd7, 9'd8, 1'b0);
    drain(60);

    // back-pressure during completion
    out_ready = 1'b0;
    fork
      begin
        group(4, 1'b1, 11'd100, 9'd200, 1'b0);
        group(5, 1'b1, 11'd7, 9'd9, 1'b0);
        group(3, 1'b1, 11'd1000, 9'd300, 1'b0);
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!ov0 && k < 100) begin
          @(negedge clk);
          k++;
        end
        check("stall_seen", ov0, 1);
        held = od0;
        repeat (10) begin
          check("stall_ce", ce0, 0);
          check("stall_data", od0, held);
          check("stall_valid", ov0, 1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain(100);

    // bubbles do not count
    e.d0 = 3; e.d1 = 3; e.cnt = 3; e.v0 = 0; e.v1 = 0;
    sb.push_back(e);
    send(1'b1, 1'b0, 11'd1, 9'd1);
    send(1'b0, 1'b0, 11'd0, 9'd0);
    send(1'b0, 1'b0, 11'd0, 9'd0);
    send(1'b1, 1'b0, 11'd1, 9'd1);
    send(1'b1, 1'b1, 11'd1, 9'd1);
    drain(60);

    // random groups, then overflow of the 20-bit instance
    group(10, 1'b1, 11'd0, 9'd0, 1'b1);
    group(16, 1'b0, 11'd0, 9'd0, 1'b1);
    group(2, 1'b1, 11'd2047, 9'd511, 1'b0);
    drain(80);

    // reset with two products in flight
    send(1'b1, 1'b0, 11'd9, 9'd9);
    send(1'b1, 1'b0, 11'd9, 9'd9);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", ov0, 0);
    check("mid_rst_data", od0, 0);
    check("mid_rst_cnt", oc0, 0);
    check("mid_rst_ovf", ovf0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    group(3, 1'b1, 11'd3, 9'd5, 1'b0);
    drain(60);
    repeat (10) @(posedge clk);
    #1;
    check("final_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fn1_mul_acc_drain.md
Name: fn1_mul_acc_drain

Overview:
- Downstream consumer of the 11x9 unsigned pipelined multiplier (4-cycle latency, clock-enable stall).
- Drives the multiplier's `ce`, tracks which pipeline slots hold real operands, and accumulates groups of products.
- Presents each finished sum on a valid/ready output; back-pressure freezes the multiplier pipeline.
- Sits between the multiplier instance and the next dataflow stage of fn1.

Parameters:
- MUL_LAT, 4, multiplier latency in cycles; depth of the valid/last tracking shift register.
- PROD_W, 20, product width from the multiplier.
- ACC_LEN, 16, products per group; a group closes early on in_last.
- ACC_W, 24, accumulator and output width, unsigned.
- CNT_W, 5, width of the term counter; must hold ACC_LEN.

Ports:
- clk  input  1  clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented to the multiplier this cycle are real.
- in_last  input  1  qualifies in_valid; marks the final term of a group.
- in_ready  output  1  operands are accepted this cycle; equals mul_ce.
- mul_ce  output  1  clock enable to the multiplier.
- mul_dout  input  PROD_W  multiplier product output.
- out_data  output  ACC_W  completed group sum.
- out_cnt  output  CNT_W  number of terms in out_data.
- out_valid  output  1  out_data and out_cnt are valid.
- out_ready  input  1  downstream accepts the output.
- out_ovf  output  1  accumulation overflowed during this group; qualified by out_valid.

Behaviour:
- Reset (reset=0, asynchronous): vld_sr=0, last_sr=0, acc=0, cnt=0, out_valid=0, out_data=0, out_cnt=0, out_ovf=0, state=ACCUM.
- mul_ce = !(out_valid && !out_ready). The signal is combinational and has no dependency on in_valid.
- in_ready = mul_ce. An operand is accepted when in_valid && mul_ce.
- Tracking pipeline, on mul_ce=1:
  - vld_sr shifts in (in_valid), last_sr shifts in (in_valid && in_last).
  - The tail bit [MUL_LAT-1] aligns with mul_dout.
- On mul_ce=0, vld_sr, last_sr, acc and cnt all hold. The multiplier also holds because it shares the same ce.
- Product arrival: tail = mul_ce && vld_sr[MUL_LAT-1].
- Sum: nsum = acc + zero-extend(mul_dout), evaluated at ACC_W+1 bits; carry-out sets the group overflow flag.
- FSM states:
  - ACCUM: out_valid=0.
  - HOLD: out_valid=1.
- In ACCUM or HOLD with mul_ce=1 and tail:
  - If cnt+1 == ACC_LEN or last_sr tail bit is set:
    - out_data = nsum, out_cnt = cnt+1, out_ovf = group flag | carry.
    - acc=0, cnt=0, group flag cleared, next state HOLD.
  - Otherwise: acc = nsum, cnt = cnt+1, flag |= carry.
- HOLD:
  - out_ready=1 and no completion this cycle: next state ACCUM, out_valid=0.
  - out_ready=1 and a completion in the same cycle: out_data reloads, state stays HOLD (back-to-back groups, no bubble).
  - out_ready=0: mul_ce=0, everything frozen, out_* stable.
- Latency: product of an operand accepted at cycle t arrives at cycle t+MUL_LAT if no stall occurs. out_valid rises the cycle after the closing product arrives.
- Throughput: one operand per cycle while out_ready stays high.
- Boundary cases:
  - in_last on the first term closes a group with out_cnt=1.
  - Bubbles (in_valid=0) never count as terms.
  - Reset mid-group discards the partial sum and all in-flight tracking bits.
  - ACC_LEN=1 closes a group on every product.

Optional Feature:
- Macro: FN1_ACC_SAT_EN.
- Defined: on carry-out, acc and out_data clamp to 2^ACC_W-1 and remain clamped for the rest of the group. out_ovf still reports the overflow.
- Undefined: the sum wraps modulo 2^ACC_W. out_ovf still reports the overflow.

Decomposition:
- Package fn1_mul_acc_pkg holds:
  - the default constants MUL_LAT, PROD_W, ACC_W;
  - the state enum (ACCUM, HOLD);
  - a function computing the required ACC_W from PROD_W and ACC_LEN.
- One sub-module: fn1_vld_track, a parameterized ce-gated shift register carrying valid/last, MUL_LAT deep.

Test Plan:
- 16 back-to-back operands (a=2047, b=511), out_ready=1:
  - each product is 1046017;
  - out_data=16736272, out_cnt=16, out_ovf=0;
  - out_valid pulses once, 4+16 cycles after the first accept.
- 3 operands (a=3, b=5) with in_last on the third: out_data=45, out_cnt=3; the next group starts from acc=0.
- out_ready held 0 for 10 cycles during a completion:
  - mul_ce=0 and out_data stable throughout;
  - no products are lost; subsequent group sums are exact.
- Bubbles: in_valid pattern 1,0,0,1,1 with in_last on the final beat, operands a=1, b=1 → out_cnt=3, out_data=3.
- Overflow, ACC_W=20, two products of 1046017:
  - without the macro: out_data=1043458, out_ovf=1;
  - with FN1_ACC_SAT_EN: out_data=1048575, out_ovf=1.
- reset asserted with 2 products in flight → all outputs 0 immediately; after release, the first group's sum excludes the flushed products.
